// File: rtl/ep_in_arbiter.sv
// ep_in_arbiter: round-robin scheduler that shares one USB IN transmit path
// between NUM_EP endpoint byte queues. One enabled, non-empty endpoint is
// granted at a time. Its queue is popped and the bytes go out as a framed
// packet of at most MAX_PKT bytes. The queue read side has one cycle of
// latency, so tx_wr is the pop strobe delayed by one register stage.
module ep_in_arbiter #(
    parameter int NUM_EP  = 4,
    parameter int MAX_PKT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_EP-1:0]         ep_en,
    input  logic [NUM_EP-1:0]         ep_empty,
    input  logic [8*NUM_EP-1:0]       ep_data,
    output logic [NUM_EP-1:0]         ep_rd,
    input  logic                      tx_full,
    output logic                      tx_wr,
    output logic [7:0]                tx_data,
    output logic                      tx_last,
    output logic [$clog2(NUM_EP)-1:0] tx_ep,
    output logic                      busy
);

    localparam int EP_W  = $clog2(NUM_EP);
    localparam int CNT_W = $clog2(MAX_PKT + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state;
    logic [EP_W-1:0]   rr_ptr;
    logic [EP_W-1:0]   grant;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_EP-1:0] cand;
    logic [EP_W-1:0]   pick;
    logic              found;
    logic              vld_p0;
    logic              vld_p1;
    logic              last_hit;

    // Endpoint index after v, wrapping to 0 past the last endpoint so that
    // non-power-of-two endpoint counts never produce an out-of-range index.
    function automatic logic [EP_W-1:0] wrap_inc(input logic [EP_W-1:0] v);
        if (int'(v) >= NUM_EP - 1)
            return '0;
        else
            return v + EP_W'(1);
    endfunction

    assign cand = ep_en & ~ep_empty;

    // First candidate at or above rr_ptr, searching upward with wrap.
    always_comb begin
        int idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_EP; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_EP;
            if (!found && cand[idx]) begin
                pick  = EP_W'(idx);
                found = 1'b1;
            end
        end
    end

    // ---- stage p0: pop decision against the granted queue ----
    assign vld_p0 = (state == SEND) && !ep_empty[grant] && !tx_full
                    && (cnt < CNT_W'(MAX_PKT));

    // One-hot pop strobe towards the granted queue only.
    always_comb begin
        ep_rd        = '0;
        ep_rd[grant] = vld_p0;
    end

    // ---- stage p1: queue output is valid, forward it to the sink ----
    // ep_empty here already reflects the pop that produced this byte, so an
    // empty queue means this is the packet's final byte.
    assign last_hit = (cnt == CNT_W'(MAX_PKT)) || ep_empty[grant];
    assign tx_wr    = vld_p1;
    assign tx_last  = vld_p1 && last_hit;
    assign tx_data  = ep_data[8*int'(grant) +: 8];
    assign tx_ep    = grant;
    assign busy     = (state == SEND);

    // Arbitration FSM, packet byte count and the pop-to-write valid stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            cnt    <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= pick;
                        cnt   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    // A pop never coincides with the final write: both the
                    // count limit and an empty queue block the pop.
                    if (vld_p0)
                        cnt <= cnt + CNT_W'(1);
                    if (vld_p1 && last_hit) begin
                        state  <= IDLE;
                        rr_ptr <= wrap_inc(grant);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ep_in_arbiter.sv
// tb_ep_in_arbiter: directed bench for ep_in_arbiter. Endpoint queues are
// modelled as byte queues with a registered output; every pop pushes the
// expected byte to a scoreboard, compared when tx_wr appears. Completed
// packets are logged and checked against the expected arbitration order.
module tb_ep_in_arbiter;

    localparam int NUM_EP  = 4;
    localparam int MAX_PKT = 64;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_EP-1:0]         ep_en;
    logic [NUM_EP-1:0]         ep_empty;
    logic [8*NUM_EP-1:0]       ep_data;
    logic [NUM_EP-1:0]         ep_rd;
    logic                      tx_full;
    logic                      tx_wr;
    logic [7:0]                tx_data;
    logic                      tx_last;
    logic [$clog2(NUM_EP)-1:0] tx_ep;
    logic                      busy;

    always #5 clk = ~clk;

    ep_in_arbiter #(.NUM_EP(NUM_EP), .MAX_PKT(MAX_PKT)) dut (
        .clk      (clk),
        .rst      (rst),
        .ep_en    (ep_en),
        .ep_empty (ep_empty),
        .ep_data  (ep_data),
        .ep_rd    (ep_rd),
        .tx_full  (tx_full),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_ep    (tx_ep),
        .busy     (busy)
    );

    typedef struct packed {
        logic [31:0] ep;
        logic [31:0] len;
        logic [31:0] first;
        logic [31:0] last;
    } pkt_t;

    logic [7:0]  q [NUM_EP][$];
    logic [15:0] sb [$];
    pkt_t        pkts [$];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int pkt_bytes = 0;
    int pkt_first = 0;
    int wr_count  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_empty();
        for (int i = 0; i < NUM_EP; i++)
            ep_empty[i] = (q[i].size() == 0);
    endtask

    task automatic push_bytes(input int ep, input int n, input int base);
        for (int k = 0; k < n; k++)
            q[ep].push_back(8'(base + k));
        refresh_empty();
    endtask

    // Compare one written byte against the scoreboard and track packets.
    task automatic observe();
        logic [15:0] e;
        logic        exp_last;
        pkt_t        p;
        if (tx_wr) begin
            wr_count++;
            check("sb_has_entry", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                pkt_bytes++;
                if (pkt_bytes == 1)
                    pkt_first = cyc;
                exp_last = (pkt_bytes == MAX_PKT) || (q[e[15:8]].size() == 0);
                check("tx_data", 32'(tx_data), 32'(e[7:0]));
                check("tx_ep", 32'(tx_ep), 32'(e[15:8]));
                check("tx_last", 32'(tx_last), 32'(exp_last));
                check("busy_in_pkt", 32'(busy), 1);
                if (exp_last) begin
                    p.ep    = 32'(e[15:8]);
                    p.len   = 32'(pkt_bytes);
                    p.first = 32'(pkt_first);
                    p.last  = 32'(cyc);
                    pkts.push_back(p);
                    pkt_bytes = 0;
                end
            end
        end
    endtask

    // One clock cycle; entered and left at the falling edge.
    task automatic tick();
        logic [NUM_EP-1:0] rd;
        logic [7:0]        b;
        #2;
        rd = ep_rd;
        if (!rst)
            check("ep_rd_onehot", 32'($onehot0(rd)), 1);
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NUM_EP; i++) begin
            if (rd[i] === 1'b1) begin
                check("pop_nonempty", 32'(q[i].size() > 0), 1);
                if (q[i].size() > 0) begin
                    b = q[i].pop_front();
                    ep_data[8*i +: 8] = b;
                    sb.push_back({8'(i), b});
                end
            end
        end
        refresh_empty();
        @(negedge clk);
        observe();
    endtask

    function automatic bit quiet();
        return !busy && !tx_wr && (sb.size() == 0) && ((ep_en & ~ep_empty) == '0);
    endfunction

    task automatic drain(input int maxc, input string tag);
        int n = 0;
        while (n < maxc && !quiet()) begin
            tick();
            n++;
        end
        check({"drain_", tag}, 32'(quiet()), 1);
    endtask

    task automatic wait_bytes(input int nb, input int maxc, input string tag);
        int n = 0;
        while (n < maxc && pkt_bytes != nb) begin
            tick();
            n++;
        end
        check({"reach_byte_", tag}, 32'(pkt_bytes), 32'(nb));
    endtask

    task automatic expect_pkt(input int idx, input int ep, input int len);
        if (idx < pkts.size()) begin
            check($sformatf("pkt%0d_ep", idx), pkts[idx].ep, 32'(ep));
            check($sformatf("pkt%0d_len", idx), pkts[idx].len, 32'(len));
        end else begin
            check($sformatf("pkt%0d_present", idx), 32'(pkts.size()), 32'(idx + 1));
        end
    endtask

    task automatic reset_dut(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        sb.delete();
        pkts.delete();
        pkt_bytes = 0;
    endtask

    initial begin
        int c0;
        int n;
        int wr0;
        int rem;

        rst     = 1'b1;
        ep_en   = 4'b1111;
        tx_full = 1'b0;
        ep_data = '0;
        refresh_empty();

        // Reset state
        reset_dut(3);
        check("rst_ep_rd", 32'(ep_rd), 0);
        check("rst_tx_wr", 32'(tx_wr), 0);
        check("rst_tx_last", 32'(tx_last), 0);
        check("rst_tx_ep", 32'(tx_ep), 0);
        check("rst_busy", 32'(busy), 0);
        tick();
        check("idle_busy", 32'(busy), 0);

        // Three-byte packet on EP1
        c0 = cyc;
        push_bytes(1, 3, 'hA0);
        drain(40, "ep1");
        check("t1_count", 32'(pkts.size()), 1);
        expect_pkt(0, 1, 3);
        if (pkts.size() > 0) begin
            check("t1_first_latency", pkts[0].first, 32'(c0 + 2));
            check("t1_back_to_back", pkts[0].last - pkts[0].first, 2);
            check("t1_idle_next", 32'(cyc), pkts[0].last + 1);
        end

        // 70 bytes on EP0: packet of MAX_PKT then packet of 6
        pkts.delete();
        push_bytes(0, 70, 0);
        drain(400, "ep0_long");
        check("t2_count", 32'(pkts.size()), 2);
        expect_pkt(0, 0, 64);
        expect_pkt(1, 0, 6);
        if (pkts.size() > 1)
            check("t2_gap", pkts[1].first - pkts[0].last, 3);

        // Round robin over all endpoints, then refill EP0/EP2 mid-round
        reset_dut(2);
        push_bytes(0, 2, 'h10);
        push_bytes(1, 2, 'h20);
        push_bytes(2, 2, 'h30);
        push_bytes(3, 2, 'h40);
        n = 0;
        while (n < 100 && pkts.size() < 2) begin
            tick();
            n++;
        end
        check("t3_two_pkts", 32'(pkts.size()), 2);
        push_bytes(0, 2, 'h50);
        push_bytes(2, 2, 'h60);
        drain(200, "rr");
        check("t3_count", 32'(pkts.size()), 5);
        expect_pkt(0, 0, 2);
        expect_pkt(1, 1, 2);
        expect_pkt(2, 2, 4);
        expect_pkt(3, 3, 2);
        expect_pkt(4, 0, 2);

        // Back-pressure on EP2 after byte 4
        pkts.delete();
        push_bytes(2, 10, 'h80);
        wait_bytes(4, 50, "full");
        tx_full = 1'b1;
        wr0 = wr_count;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("full_no_pop", 32'(ep_rd), 0);
            tick();
        end
        check("full_extra_le1", 32'((wr_count - wr0) <= 1), 1);
        tx_full = 1'b0;
        drain(100, "full");
        check("t4_count", 32'(pkts.size()), 1);
        expect_pkt(0, 2, 10);

        // Reset during byte 5 of a 20-byte EP3 packet
        pkts.delete();
        push_bytes(3, 20, 'hC0);
        wait_bytes(5, 60, "rst");
        rst = 1'b1;
        push_bytes(1, 2, 'hE0);
        tick();
        check("mid_rst_tx_wr", 32'(tx_wr), 0);
        check("mid_rst_ep_rd", 32'(ep_rd), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_tx_ep", 32'(tx_ep), 0);
        sb.delete();
        pkts.delete();
        pkt_bytes = 0;
        rem = q[3].size();
        rst = 1'b0;
        drain(100, "after_rst");
        check("t5_count", 32'(pkts.size()), 2);
        expect_pkt(0, 1, 2);
        expect_pkt(1, 3, rem);

        // Disabled endpoint is skipped, then granted once enabled
        pkts.delete();
        ep_en = 4'b1011;
        push_bytes(2, 3, 'h90);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("dis_busy", 32'(busy), 0);
            check("dis_ep_rd", 32'(ep_rd), 0);
        end
        ep_en = 4'b1111;
        tick();
        check("en_granted", 32'(busy), 1);
        check("en_tx_ep", 32'(tx_ep), 2);
        ep_en = 4'b1011;
        drain(50, "en");
        check("t6_count", 32'(pkts.size()), 1);
        expect_pkt(0, 2, 3);
        ep_en = 4'b1111;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ep_in_arbiter.md
# ep_in_arbiter

Round-robin scheduler that shares one downstream USB IN transmit path between `NUM_EP` endpoint byte queues. It grants one non-empty, enabled endpoint at a time, pops its queue, and forwards bytes as a framed packet of at most `MAX_PKT` bytes. It sits between the per-endpoint `queue` instances (read side) and the packetizer/transmit FIFO.

## Interface
- `NUM_EP`, default 4: number of endpoint queues, ≥2.
- `MAX_PKT`, default 64: maximum bytes per packet, ≥1.
- `clk` in 1: single clock; all endpoint queue read sides and the transmit sink run on it.
- `rst` in 1: synchronous, active-high reset.
- `ep_en` in NUM_EP: per-endpoint enable; bit i=0 excludes endpoint i from arbitration.
- `ep_empty` in NUM_EP: queue i empty flag.
- `ep_data` in 8*NUM_EP: queue i data at bits [8i+7:8i]; registered queue output, valid the cycle after a pop.
- `ep_rd` out NUM_EP: one-hot pop strobe, at most one bit high.
- `tx_full` in 1: sink cannot take more than one further byte.
- `tx_wr` out 1: byte valid strobe.
- `tx_data` out 8: byte being written.
- `tx_last` out 1: qualifies `tx_wr`; final byte of packet.
- `tx_ep` out $clog2(NUM_EP): granted endpoint index, stable for the whole packet.
- `busy` out 1: high in SEND.

## Operation
- States: IDLE, SEND.
- IDLE: candidate set = `ep_en & ~ep_empty`. If non-empty, grant the first candidate found searching upward from `rr_ptr` with wrap. Register `grant`, set `tx_ep`, clear `cnt`, go to SEND. Otherwise stay in IDLE.
- SEND pop condition: `~ep_empty[grant] & ~tx_full & (cnt < MAX_PKT)`. When it holds, assert `ep_rd[grant]` and increment `cnt`.
- `tx_wr` = pop registered one cycle. `tx_data = ep_data[grant]` in that cycle.
- `tx_last` during a `tx_wr` cycle = `(cnt == MAX_PKT) | ep_empty[grant]`. `ep_empty` in that cycle already reflects the previous pop.
- A `tx_wr` with `tx_last` ends the packet: next state IDLE, `rr_ptr <= grant+1` (wraps to 0 after NUM_EP-1).
- `tx_full` high stalls popping only; it never ends a packet.
- Only this block reads the queues, so `ep_empty[grant]` cannot rise during SEND except by its own pops.
- Clearing `ep_en[grant]` during SEND has no effect until the packet ends.
- `cnt` width = $clog2(MAX_PKT+1); it never exceeds MAX_PKT.
- Reset values: state IDLE, `rr_ptr` 0, `grant` 0, `cnt` 0. Outputs: `ep_rd` 0, `tx_wr` 0, `tx_last` 0, `tx_ep` 0, `busy` 0, `tx_data` don't-care while `tx_wr` is 0.
- Reset mid-packet: the packet is abandoned. No `tx_last` is issued, and a byte popped in the reset cycle is discarded. The sink is reset alongside.

## Timing
- Pop at cycle N → `tx_wr`/`tx_data` at N+1 (latency 1).
- Back-to-back pops give one byte per cycle.
- Sink headroom: a pop in cycle N with `tx_full` low may still land after the N+1 write. `tx_full` must therefore assert when ≤1 entry remains free.
- Grant to first pop: IDLE grant edge at cycle G, first pop at G+1, first `tx_wr` at G+2.
- Packet end to next grant: `tx_last` at cycle L, IDLE at L+1, next SEND at L+2.
- Single-byte packet: one pop, one `tx_wr` with `tx_last`=1.
- When exactly MAX_PKT bytes remain, the packet ends on count. The queue is then empty on the next grant attempt, so no zero-length packet is generated.

## Test plan
- EP1 holds 3 bytes A0,A1,A2, others empty, `tx_full`=0 → three consecutive `tx_wr` with data A0,A1,A2, `tx_ep`=1, `tx_last` only on A2, back in IDLE one cycle later.
- EP0 holds 70 bytes, MAX_PKT=64 → packet of 64 (`tx_last` on byte 64), then packet of 6. No `tx_wr` during the gap of ≥2 cycles between them.
- All four EPs hold 2 bytes, `rr_ptr`=0 → packets in order EP0,EP1,EP2,EP3. Refill EP0 and EP2 after the EP1 packet → EP2 served before EP0.
- EP2 holds 10 bytes, `tx_full` forced high for 5 cycles after byte 4 → at most 1 extra `tx_wr` after `tx_full` rises. Stream resumes with the same packet: 10 bytes total, single `tx_last`, no data loss.
- Reset pulsed during byte 5 of a 20-byte EP3 packet → next cycle `tx_wr`/`ep_rd`/`busy` = 0, `rr_ptr` 0. Subsequent arbitration restarts from EP0 and EP3 sends its remaining bytes as a new packet.
- `ep_en`=4'b1011, EP2 non-empty, others empty → no grant, `busy` stays 0. Set `ep_en[2]` → EP2 granted within 1 cycle.
